dsp_mac_sequencer: RTL and testbench

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

---
 rtl/dsp_mac_sequencer_pkg.sv | 23 ++
 rtl/dsp_mac_sequencer_beat.sv | 43 ++++
 rtl/dsp_mac_sequencer.sv | 126 ++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and constants for the DSP-slice dot-product sequencer.
package dsp_mac_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    FLUSH1 = 3'd2,
    FLUSH2 = 3'd3,
    RESULT = 3'd4
  } mac_state_e;

  // OPMODE encodings: bit 0 selects X=M, bit 3 selects Z=P.
  localparam logic [7:0] OPMODE_FIRST = 8'h01;
  localparam logic [7:0] OPMODE_ACC   = 8'h09;
  localparam logic [7:0] OPMODE_HOLD  = 8'h08;

  // Clock-enabled edges between an operand beat and P capturing its product.
  localparam int SLICE_DEPTH = 2;

  localparam int OPND_W = 18;
  localparam int ACC_W  = 48;

endpackage

// File: rtl/dsp_mac_sequencer_beat.sv
// Tracks which slice-enabled edges load P with an element of the current
// vector and accumulates the sticky carry-out flag from those captures.
module mac_beat_tracker
  import dsp_mac_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ce_i,
  input  logic beat_i,
  input  logic first_beat_i,
  input  logic carryout_i,
  output logic ovf_o
);

  logic [SLICE_DEPTH-1:0] bv_q, bv_d;
  logic                   cap_q, cap_d;
  logic                   ovf_q, ovf_d;

  always_comb begin
    bv_d  = bv_q;
    cap_d = ce_i & bv_q[SLICE_DEPTH-1];
    ovf_d = ovf_q;
    if (ce_i) bv_d = {bv_q[SLICE_DEPTH-2:0], beat_i};
    // CARRYOUT is registered alongside P, so it is valid the cycle after capture.
    if (first_beat_i)             ovf_d = 1'b0;
    else if (cap_q && carryout_i) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bv_q  <= '0;
      cap_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      bv_q  <= bv_d;
      cap_q <= cap_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q | (cap_q & carryout_i);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams operand pairs into a pipelined DSP slice (A1/B1, M, P, OPMODE regs)
// and returns the accumulated dot product, element count and overflow flag.
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [OPND_W-1:0] s_a,
  input  logic [OPND_W-1:0] s_b,
  input  logic              s_last,
  output logic [OPND_W-1:0] dsp_a,
  output logic [OPND_W-1:0] dsp_b,
  output logic [OPND_W-1:0] dsp_d,
  output logic [ACC_W-1:0]  dsp_c,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_ce,
  output logic              dsp_rst,
  input  logic [ACC_W-1:0]  dsp_p,
  input  logic              dsp_carryout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_ovf,
  output mac_state_e        dbg_state
);

  // Handshakes: s_* and res_* transfer on a cycle where valid and ready are
  // both high; res_valid/res_data hold steady until res_ready is seen.

  mac_state_e       state_q, state_d;
  logic [7:0]       pend_op_q, pend_op_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             beat;
  logic             first_beat;
  logic             ovf;

  always_comb begin
    state_d    = state_q;
    pend_op_d  = pend_op_q;
    count_d    = count_q;
    s_ready    = rst_n && (state_q == IDLE || state_q == ACCUM);
    beat       = s_valid && s_ready;
    first_beat = beat && (state_q == IDLE);
    dsp_ce     = 1'b0;
    dsp_a      = '0;
    dsp_b      = '0;
    dsp_opmode = OPMODE_HOLD;
    res_valid  = 1'b0;

    if (beat) begin
      dsp_ce    = 1'b1;
      dsp_a     = s_a;
      dsp_b     = s_b;
      // An element's OPMODE trails its operands by one enabled cycle.
      pend_op_d = first_beat ? OPMODE_FIRST : OPMODE_ACC;
      if (first_beat)          count_d = CNT_W'(1);
      else if (count_q != '1)  count_d = count_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (beat) state_d = s_last ? FLUSH1 : ACCUM;
      end
      ACCUM: begin
        dsp_opmode = pend_op_q;
        if (beat && s_last) state_d = FLUSH1;
      end
      FLUSH1: begin
        dsp_ce     = 1'b1;
        dsp_opmode = pend_op_q;
        state_d    = FLUSH2;
      end
      FLUSH2: begin
        dsp_ce  = 1'b1;
        state_d = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      dsp_ce     = 1'b0;
      dsp_opmode = OPMODE_HOLD;
      res_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_op_q <= OPMODE_HOLD;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_op_q <= pend_op_d;
      count_q   <= count_d;
    end
  end

  mac_beat_tracker u_beat_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce_i         (dsp_ce),
    .beat_i       (beat),
    .first_beat_i (first_beat),
    .carryout_i   (dsp_carryout),
    .ovf_o        (ovf)
  );

  assign dsp_rst   = ~rst_n;
  assign dsp_d     = '0;
  assign dsp_c     = '0;
  assign res_data  = dsp_p;
  assign res_count = rst_n ? count_q : '0;
  assign res_ovf   = rst_n & ovf;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench: behavioural DSP slice, randomized and directed vectors checked
// against a dot-product reference computed with plain arithmetic.
module tb_dsp_mac_sequencer;
  import dsp_mac_sequencer_pkg::*;

  localparam int CNT_W = 16;
  localparam int MAX_N = 4200;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [17:0]      s_a = '0;
  logic [17:0]      s_b = '0;
  logic             s_last = 1'b0;
  logic [17:0]      dsp_a, dsp_b, dsp_d;
  logic [47:0]      dsp_c;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce, dsp_rst;
  logic [47:0]      dsp_p;
  logic             dsp_carryout;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [47:0]      res_data;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;
  mac_state_e       dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [17:0] va [MAX_N];
  logic [17:0] vb [MAX_N];
  logic [47:0] exp_q [$];
  logic [63:0] exp_cnt_q [$];
  logic        exp_ovf_q [$];

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_a          (s_a),
    .s_b          (s_b),
    .s_last       (s_last),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_d        (dsp_d),
    .dsp_c        (dsp_c),
    .dsp_opmode   (dsp_opmode),
    .dsp_ce       (dsp_ce),
    .dsp_rst      (dsp_rst),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_count    (res_count),
    .res_ovf      (res_ovf),
    .dbg_state    (dbg_state)
  );

  // DSP slice model: A1REG=B1REG=MREG=PREG=OPMODREG=CARRYOUTREG=1.
  logic [17:0] sl_a_q, sl_b_q;
  logic [47:0] sl_m_q, sl_p_q;
  logic [7:0]  sl_op_q;
  logic        sl_co_q;
  logic [48:0] sl_sum;

  always_comb sl_sum = {1'b0, (sl_op_q[3] ? sl_p_q : 48'd0)}
                     + {1'b0, (sl_op_q[0] ? sl_m_q : 48'd0)};

  always_ff @(posedge clk) begin
    if (dsp_rst) begin
      sl_a_q <= '0; sl_b_q <= '0; sl_m_q <= '0;
      sl_p_q <= '0; sl_op_q <= '0; sl_co_q <= 1'b0;
    end else if (dsp_ce) begin
      sl_a_q  <= dsp_a;
      sl_b_q  <= dsp_b;
      sl_m_q  <= {30'd0, sl_a_q} * {30'd0, sl_b_q};
      sl_op_q <= dsp_opmode;
      sl_p_q  <= sl_sum[47:0];
      sl_co_q <= sl_sum[48];
    end
  end

  assign dsp_p        = sl_p_q;
  assign dsp_carryout = sl_co_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_elems(input int n, input int gap_at, input int gap_len, input bit with_last);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          s_valid = 1'b0;
          #1 check("gap_ce", 64'(dsp_ce), 64'd0);
        end
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_a     = va[i];
      s_b     = vb[i];
      s_last  = with_last && (i == n - 1);
      #1 if (!s_ready) check("s_ready_beat", 64'(s_ready), 64'd1);
      @(posedge clk);
    end
  endtask

  task automatic run_vector(input int n, input int gap_at, input int gap_len, input int hold);
    logic [63:0] exact;
    logic [63:0] cnt;
    logic [47:0] exp_d;
    int lat;
    exact = '0;
    for (int i = 0; i < n; i++) exact += 64'(va[i]) * 64'(vb[i]);
    cnt = (n > 65535) ? 64'd65535 : 64'(n);
    exp_q.push_back(exact[47:0]);
    exp_cnt_q.push_back(cnt);
    exp_ovf_q.push_back(exact[63:48] != 16'd0);

    send_elems(n, gap_at, gap_len, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      lat++;
    end while (!res_valid && lat < 20);
    check("latency", 64'(lat), 64'd3);

    exp_d = exp_q.pop_front();
    check("res_data", 64'(res_data), 64'(exp_d));
    check("res_count", 64'(res_count), exp_cnt_q.pop_front());
    check("res_ovf", 64'(res_ovf), 64'(exp_ovf_q.pop_front()));
    check("s_ready_result", 64'(s_ready), 64'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_data", 64'(res_data), 64'(exp_d));
      check("hold_s_ready", 64'(s_ready), 64'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 64'(res_valid), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_ce"}, 64'(dsp_ce), 64'd0);
    check({tag, "_rst"}, 64'(dsp_rst), 64'd1);
    check({tag, "_opmode"}, 64'(dsp_opmode), 64'h08);
    check({tag, "_a"}, 64'(dsp_a), 64'd0);
    check({tag, "_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_count"}, 64'(res_count), 64'd0);
    check({tag, "_ovf"}, 64'(res_ovf), 64'd0);
  endtask

  task automatic load_1234;
    for (int i = 0; i < 4; i++) begin
      va[i] = 18'(i + 1);
      vb[i] = 18'(i + 5);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap_at;
    repeat (2) @(negedge clk);
    check_reset("rst");
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_s_ready", 64'(s_ready), 64'd1);
    check("idle_opmode", 64'(dsp_opmode), 64'h08);

    va[0] = 18'd3; vb[0] = 18'd4;
    run_vector(1, -1, 0, 0);

    load_1234();
    run_vector(4, -1, 0, 0);
    run_vector(4, 2, 5, 0);
    run_vector(4, -1, 0, 10);
    va[0] = 18'd2; vb[0] = 18'd2;
    run_vector(1, -1, 0, 0);

    for (int i = 0; i < 4097; i++) begin
      va[i] = 18'd262143;
      vb[i] = 18'd262143;
    end
    run_vector(4097, -1, 0, 1);

    // Reset with two elements of a vector already in the slice.
    load_1234();
    send_elems(2, -1, 0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_vector(4, -1, 0, 0);

    for (int v = 0; v < 10; v++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        va[i] = 18'($urandom_range(0, 262143));
        vb[i] = 18'($urandom_range(0, 262143));
      end
      gap_at = (n > 1) ? $urandom_range(1, n - 1) : -1;
      run_vector(n, gap_at, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
